hist2d_read_bins: RTL and testbench

- Reader side of the 2D IQ histogram BRAM: scans every bin filled by the bin-store logic and streams (i_coord, q_coord, count) tuples out over a valid/ready interface.
- Feeds downstream export or display logic (UART dump, VGA heatmap).
- Owns the BRAM address/write port while scanning; the store path must be idle during a scan.

---
 rtl/hist2d_read_bins_if.sv | 35 +++
 rtl/hist2d_read_bins.sv | 208 ++++++++++++++++++++
 tb/tb_hist2d_read_bins.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hist2d_read_bins_if.sv
// Bundles the control, BRAM-port and tuple-stream signals of hist2d_read_bins.
// The master modport is the scanner side; the slave modport faces it (BRAM plus consumer).
interface hist2d_read_bins_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              start;
  logic [7:0]        i_bin_num;
  logic [7:0]        q_bin_num;
  logic [DATA_W-1:0] mem_read_val;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_write;
  logic [DATA_W-1:0] mem_write_val;
  logic [7:0]        out_i_coord;
  logic [7:0]        out_q_coord;
  logic [DATA_W-1:0] out_count;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] max_count;

  modport master (
    input  start, i_bin_num, q_bin_num, mem_read_val, out_ready,
    output mem_address, mem_write, mem_write_val, out_i_coord, out_q_coord, out_count,
           out_valid, out_last, busy, done, max_count
  );

  modport slave (
    output start, i_bin_num, q_bin_num, mem_read_val, out_ready,
    input  mem_address, mem_write, mem_write_val, out_i_coord, out_q_coord, out_count,
           out_valid, out_last, busy, done, max_count
  );
endinterface

// File: rtl/hist2d_read_bins.sv
// Reader for the 2D IQ histogram BRAM: scans every bin (i outer, q inner) and streams
// (i, q, count) tuples. Define HIST2D_CLEAR_ON_READ_EN to zero each bin after hand-off.
module hist2d_read_bins #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned READ_LATENCY = 2
) (
  input logic                clk100,
  input logic                reset_n,
  hist2d_read_bins_if.master bus
);

  localparam int unsigned LatW = 3;

`ifdef HIST2D_CLEAR_ON_READ_EN
  typedef enum logic [2:0] {StIdle, StAddr, StWait, StPresent, StClear, StFin} state_e;
`else
  typedef enum logic [2:0] {StIdle, StAddr, StWait, StPresent, StFin} state_e;
`endif

  state_e            state_q, state_d;
  logic [7:0]        i_num_q, i_num_d;
  logic [7:0]        q_num_q, q_num_d;
  logic [7:0]        i_q, i_d;
  logic [7:0]        q_q, q_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LatW-1:0]   lat_q, lat_d;
  logic [7:0]        ic_q, ic_d;
  logic [7:0]        qc_q, qc_d;
  logic [DATA_W-1:0] count_q, count_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] max_q, max_d;
`ifdef HIST2D_CLEAR_ON_READ_EN
  logic              wr_q, wr_d;
`endif

  logic at_q_end;
  logic at_end;
  logic advance;

  assign at_q_end = (q_q == q_num_q - 8'd1);
  assign at_end   = at_q_end && (i_q == i_num_q - 8'd1);

  always_comb begin
    state_d = state_q;
    i_num_d = i_num_q;
    q_num_d = q_num_q;
    i_d     = i_q;
    q_d     = q_q;
    addr_d  = addr_q;
    lat_d   = lat_q;
    ic_d    = ic_q;
    qc_d    = qc_q;
    count_d = count_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    max_d   = max_q;
    advance = 1'b0;
`ifdef HIST2D_CLEAR_ON_READ_EN
    wr_d    = 1'b0;
`endif

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          i_num_d = bus.i_bin_num;
          q_num_d = bus.q_bin_num;
          i_d     = 8'd0;
          q_d     = 8'd0;
          addr_d  = '0;
          max_d   = '0;
          busy_d  = 1'b1;
          if ((bus.i_bin_num == 8'd0) || (bus.q_bin_num == 8'd0)) begin
            state_d = StFin;
          end else begin
            state_d = StAddr;
          end
        end
      end

      // The address register is already current here, so this cycle is the first latency cycle.
      StAddr: begin
        lat_d   = LatW'(READ_LATENCY);
        state_d = StWait;
      end

      StWait: begin
        lat_d = lat_q - LatW'(1);
        if (lat_q == LatW'(1)) begin
          count_d = bus.mem_read_val;
          ic_d    = i_q;
          qc_d    = q_q;
          valid_d = 1'b1;
          last_d  = at_end;
          if (bus.mem_read_val > max_q) begin
            max_d = bus.mem_read_val;
          end
          state_d = StPresent;
        end
      end

      StPresent: begin
        if (valid_q && bus.out_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
`ifdef HIST2D_CLEAR_ON_READ_EN
          wr_d    = 1'b1;
          state_d = StClear;
`else
          advance = 1'b1;
`endif
        end
      end

`ifdef HIST2D_CLEAR_ON_READ_EN
      // Write strobe is live for this one cycle at the address just handed off.
      StClear: begin
        advance = 1'b1;
      end
`endif

      StFin: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Linear scan order makes i * Q + q a running counter.
    if (advance) begin
      if (at_end) begin
        state_d = StFin;
      end else begin
        state_d = StAddr;
        addr_d  = addr_q + ADDR_W'(1);
        if (at_q_end) begin
          q_d = 8'd0;
          i_d = i_q + 8'd1;
        end else begin
          q_d = q_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk100) begin
    if (!reset_n) begin
      state_q <= StIdle;
      i_num_q <= 8'd0;
      q_num_q <= 8'd0;
      i_q     <= 8'd0;
      q_q     <= 8'd0;
      addr_q  <= '0;
      lat_q   <= '0;
      ic_q    <= 8'd0;
      qc_q    <= 8'd0;
      count_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      max_q   <= '0;
`ifdef HIST2D_CLEAR_ON_READ_EN
      wr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      i_num_q <= i_num_d;
      q_num_q <= q_num_d;
      i_q     <= i_d;
      q_q     <= q_d;
      addr_q  <= addr_d;
      lat_q   <= lat_d;
      ic_q    <= ic_d;
      qc_q    <= qc_d;
      count_q <= count_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      max_q   <= max_d;
`ifdef HIST2D_CLEAR_ON_READ_EN
      wr_q    <= wr_d;
`endif
    end
  end

  assign bus.mem_address   = addr_q;
`ifdef HIST2D_CLEAR_ON_READ_EN
  assign bus.mem_write     = wr_q;
`else
  assign bus.mem_write     = 1'b0;
`endif
  assign bus.mem_write_val = '0;
  assign bus.out_i_coord   = ic_q;
  assign bus.out_q_coord   = qc_q;
  assign bus.out_count     = count_q;
  assign bus.out_valid     = valid_q;
  assign bus.out_last      = last_q;
  assign bus.busy          = busy_q;
  assign bus.done          = (state_q == StFin);
  assign bus.max_count     = max_q;

endmodule

// File: tb/tb_hist2d_read_bins.sv
// Directed bench for hist2d_read_bins with a 2-cycle-latency BRAM model.
// Honours HIST2D_CLEAR_ON_READ_EN the same way the design does.
module tb_hist2d_read_bins;

  localparam int unsigned Rl = 2;
`ifdef HIST2D_CLEAR_ON_READ_EN
  localparam int Per = 5;  // ADDR + 2 WAIT + PRESENT + CLEAR
`else
  localparam int Per = 4;  // ADDR + 2 WAIT + PRESENT
`endif

  logic clk100 = 1'b0;
  logic reset_n;

  hist2d_read_bins_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  hist2d_read_bins #(
    .ADDR_W      (16),
    .DATA_W      (16),
    .READ_LATENCY(Rl)
  ) dut (
    .clk100 (clk100),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk100 = ~clk100;

  // BRAM model: two read pipeline stages, one write port shared with the bench loader.
  logic [15:0] mem [0:63];
  logic [15:0] rd0, rd1;
  logic        ld_en;
  logic [5:0]  ld_addr;
  logic [15:0] ld_val;

  always @(posedge clk100) begin
    if (ld_en) mem[ld_addr] <= ld_val;
    else if (bus.mem_write === 1'b1) mem[bus.mem_address[5:0]] <= bus.mem_write_val;
    rd0 <= mem[bus.mem_address[5:0]];
    rd1 <= rd0;
  end
  assign bus.mem_read_val = rd1;

  int n_wr = 0;
  int n_wr_bad = 0;
  always @(negedge clk100) begin
    if (bus.mem_write === 1'b1) begin
      n_wr <= n_wr + 1;
      if (bus.mem_write_val !== 16'd0) n_wr_bad <= n_wr_bad + 1;
    end
  end

  int n_total = 0;
  int n_bad = 0;

  int          n_got, bcyc, done_cyc, last_cyc, done_seen, cur_q;
  logic [7:0]  got_i [0:15];
  logic [7:0]  got_q [0:15];
  logic [15:0] got_c [0:15];
  logic        got_l [0:15];
  logic [15:0] exp_cnt [0:5];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load_mem();
    ld_en = 1'b1;
    for (int a = 0; a < 64; a++) begin
      ld_addr = 6'(a);
      ld_val  = (a == 1) ? 16'd3 : (a == 5) ? 16'd5 : 16'd0;
      @(negedge clk100);
    end
    ld_en = 1'b0;
    @(negedge clk100);
  endtask

  task automatic start_scan(input logic [7:0] ib, input logic [7:0] qb);
    @(negedge clk100);
    bus.i_bin_num = ib;
    bus.q_bin_num = qb;
    bus.start     = 1'b1;
  endtask

  task automatic run_scan(input int stall_at, input int stall_cyc, input int poke, input int abort_n);
    int cyc;
    int stall_left;
    int stalled;
    int k;
    cyc = 0; stall_left = 0; stalled = 0;
    n_got = 0; bcyc = 0; done_seen = 0; done_cyc = -1; last_cyc = -1;
    bus.out_ready = 1'b1;
    while (done_seen == 0 && cyc < 400 && n_got != abort_n) begin
      @(negedge clk100);
      cyc++;
      bus.start = 1'b0;
      if (bus.busy === 1'b1) bcyc++;
      if (bus.done === 1'b1) begin
        done_seen = 1;
        done_cyc  = cyc;
      end
      if (bus.out_valid === 1'b1) begin
        k = n_got;
        if (stall_left > 0) begin
          check_eq("stall_hold",
                   {bus.out_valid, bus.out_i_coord, bus.out_q_coord, bus.out_count, bus.mem_address},
                   {1'b1, 8'(k / cur_q), 8'(k % cur_q), exp_cnt[k], 16'(k)});
          stall_left--;
          if (stall_left == 0) bus.out_ready = 1'b1;
        end else if (k == stall_at && stalled == 0) begin
          bus.out_ready = 1'b0;
          stall_left    = stall_cyc;
          stalled       = 1;
        end
        if (bus.out_ready === 1'b1) begin
          got_i[k] = bus.out_i_coord;
          got_q[k] = bus.out_q_coord;
          got_c[k] = bus.out_count;
          got_l[k] = bus.out_last;
          last_cyc = cyc;
          n_got++;
          if (poke != 0 && n_got == 2) begin
            bus.i_bin_num = 8'd1;
            bus.q_bin_num = 8'd1;
            bus.start     = 1'b1;
          end
        end
      end
    end
    bus.start = 1'b0;
    if (abort_n < 0) check_eq("scan_done_seen", done_seen, 1);
    else             check_eq("scan_abort_n", n_got, abort_n);
  endtask

  task automatic check_tuples(input string tag, input int n, input int extra);
    check_eq({tag, "_ntuples"}, n_got, n);
    for (int k = 0; k < n && k < n_got; k++) begin
      check_eq({tag, "_tuple"}, {got_i[k], got_q[k], got_c[k], got_l[k]},
               {8'(k / cur_q), 8'(k % cur_q), exp_cnt[k], (k == n - 1)});
    end
    if (n > 0) check_eq({tag, "_done_lat"}, done_cyc, last_cyc + 1);
    check_eq({tag, "_busy_cyc"}, bcyc, n * Per + 1 + extra);
    @(negedge clk100);
    check_eq({tag, "_done_pulse"}, {bus.done, bus.busy}, 2'b00);
  endtask

  initial begin
    int nd;
    int wr0;
    reset_n = 1'b0;
    bus.start = 1'b0;
    bus.i_bin_num = 8'd0;
    bus.q_bin_num = 8'd0;
    bus.out_ready = 1'b0;
    ld_en = 1'b0;
    ld_addr = 6'd0;
    ld_val = 16'd0;
    cur_q = 3;
    repeat (3) @(negedge clk100);
    check_eq("rst_mem", {bus.mem_address, bus.mem_write, bus.mem_write_val}, 64'd0);
    check_eq("rst_out", {bus.out_i_coord, bus.out_q_coord, bus.out_count, bus.out_valid,
                         bus.out_last}, 64'd0);
    check_eq("rst_ctl", {bus.busy, bus.done, bus.max_count}, 64'd0);
    reset_n = 1'b1;

    // Basic 2x3 scan.
    exp_cnt = '{16'd0, 16'd3, 16'd0, 16'd0, 16'd0, 16'd5};
    load_mem();
    start_scan(8'd2, 8'd3);
    run_scan(-1, 0, 0, -1);
    check_tuples("t1", 6, 0);
    check_eq("t1_max", bus.max_count, 16'd5);

    // Start pulsed mid-scan with different bin numbers is ignored.
    load_mem();
    start_scan(8'd2, 8'd3);
    run_scan(-1, 0, 1, -1);
    check_tuples("t5", 6, 0);
    check_eq("t5_max", bus.max_count, 16'd5);

    // Back-pressure on the second tuple for 10 cycles.
    load_mem();
    start_scan(8'd2, 8'd3);
    run_scan(1, 10, 0, -1);
    check_tuples("t2", 6, 10);

    // Zero I bins: no tuples, one busy cycle, max cleared.
    start_scan(8'd0, 8'd4);
    run_scan(-1, 0, 0, -1);
    check_tuples("t3", 0, 0);
    check_eq("t3_max", bus.max_count, 16'd0);

    // Reset after the third tuple aborts without a done pulse.
    load_mem();
    start_scan(8'd2, 8'd3);
    run_scan(-1, 0, 0, 3);
    @(negedge clk100);
    reset_n = 1'b0;
    @(negedge clk100);
    check_eq("t4_rst_mem", {bus.mem_address, bus.mem_write, bus.mem_write_val}, 64'd0);
    check_eq("t4_rst_out", {bus.out_i_coord, bus.out_q_coord, bus.out_count, bus.out_valid,
                            bus.out_last}, 64'd0);
    check_eq("t4_rst_ctl", {bus.busy, bus.done, bus.max_count}, 64'd0);
    reset_n = 1'b1;
    nd = 0;
    repeat (10) begin
      @(negedge clk100);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) nd++;
    end
    check_eq("t4_idle_after_rst", nd, 0);
    load_mem();
    start_scan(8'd2, 8'd3);
    run_scan(-1, 0, 0, -1);
    check_tuples("t4_rescan", 6, 0);
    check_eq("t4_max", bus.max_count, 16'd5);

    // Rescan behaviour: cleared histogram with clear-on-read, untouched otherwise.
`ifdef HIST2D_CLEAR_ON_READ_EN
    load_mem();
    wr0 = n_wr;
    start_scan(8'd2, 8'd3);
    run_scan(-1, 0, 0, -1);
    check_tuples("t6a", 6, 0);
    check_eq("t6a_max", bus.max_count, 16'd5);
    check_eq("t6a_writes", n_wr - wr0, 6);
    exp_cnt = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    wr0 = n_wr;
    start_scan(8'd2, 8'd3);
    run_scan(-1, 0, 0, -1);
    check_tuples("t6b", 6, 0);
    check_eq("t6b_max", bus.max_count, 16'd0);
    check_eq("t6b_writes", n_wr - wr0, 6);
`else
    wr0 = 0;
    start_scan(8'd2, 8'd3);
    run_scan(-1, 0, 0, -1);
    check_tuples("t6", 6, 0);
    check_eq("t6_max", bus.max_count, 16'd5);
    check_eq("t6_no_writes", n_wr, wr0);
`endif
    check_eq("write_val_zero", n_wr_bad, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
